rule110_gen_sequencer: RTL and testbench

//  Sequences the combinational Rule 110 next-generation core through three phases.
//  - Load: byte-serial seed load into the cell register.
//  - Step: repeated captures of the core's next generation.
//  - Dump: each generation streamed out as OUT_W-bit words over a valid/ready port.

---
 rtl/rule110_gen_sequencer.sv | 148 ++++++++++++++
 tb/tb_rule110_gen_sequencer.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rule110_gen_sequencer.sv
// Rule 110 generation sequencer: byte-serial seed load, step capture, word-serial dump.
// Optional build macro RULE110_SEQ_FREERUN_EN: a zero generation count runs until abort/reset.
module rule110_gen_sequencer #(
  parameter int unsigned WIDTH = 256,
  parameter int unsigned OUT_W = 16,
  parameter int unsigned GEN_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [GEN_W-1:0] gen_count,
  input  logic             seed_valid,
  input  logic [7:0]       seed_data,
  output logic             seed_ready,
  output logic [WIDTH-1:0] ca_cur,
  input  logic [WIDTH-1:0] ca_next,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_last,
  output logic [GEN_W-1:0] out_gen,
  output logic             busy,
  output logic             done
);

  localparam int unsigned NumBytes = WIDTH / 8;
  localparam int unsigned NumWords = WIDTH / OUT_W;
  localparam int unsigned ByteCntW = (NumBytes > 1) ? $clog2(NumBytes) : 1;
  localparam int unsigned WordIdxW = (NumWords > 1) ? $clog2(NumWords) : 1;
  localparam logic [ByteCntW-1:0] LastByte = ByteCntW'(NumBytes - 1);
  localparam logic [WordIdxW-1:0] LastWord = WordIdxW'(NumWords - 1);

  typedef enum logic [1:0] {StIdle, StLoad, StStep, StDump} state_e;

  state_e              state_q, state_d;
  logic [WIDTH-1:0]    ca_cur_q, ca_cur_d;
  logic [ByteCntW-1:0] byte_cnt_q, byte_cnt_d;
  logic [WordIdxW-1:0] word_idx_q, word_idx_d;
  logic [GEN_W-1:0]    out_gen_q, out_gen_d;
  logic [GEN_W-1:0]    gen_lat_q, gen_lat_d;
  logic                done_q, done_d;

  logic             run_forever;
  logic             word_hs;
  logic [WIDTH-1:0] word_sh;

`ifdef RULE110_SEQ_FREERUN_EN
  assign run_forever = (gen_lat_q == '0);
`else
  assign run_forever = 1'b0;
`endif

  assign word_hs = out_valid & out_ready;

  always_comb begin
    state_d    = state_q;
    ca_cur_d   = ca_cur_q;
    byte_cnt_d = byte_cnt_q;
    word_idx_d = word_idx_q;
    out_gen_d  = out_gen_q;
    gen_lat_d  = gen_lat_q;
    done_d     = 1'b0;
    if (abort) begin
      // Cell register and generation index are kept for post-abort inspection.
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            gen_lat_d  = gen_count;
            ca_cur_d   = '0;
            out_gen_d  = '0;
            byte_cnt_d = '0;
            state_d    = StLoad;
          end
        end
        StLoad: begin
          if (seed_valid) begin
            ca_cur_d   = {ca_cur_q[WIDTH-9:0], seed_data};
            byte_cnt_d = byte_cnt_q + 1'b1;
            if (byte_cnt_q == LastByte) begin
              if ((gen_lat_q != '0) || run_forever) begin
                state_d = StStep;
              end else begin
                state_d = StIdle;
                done_d  = 1'b1;
              end
            end
          end
        end
        StStep: begin
          ca_cur_d   = ca_next;
          out_gen_d  = out_gen_q + 1'b1;
          word_idx_d = '0;
          state_d    = StDump;
        end
        StDump: begin
          if (word_hs) begin
            word_idx_d = word_idx_q + 1'b1;
            if (word_idx_q == LastWord) begin
              if (!run_forever && (out_gen_q == gen_lat_q)) begin
                state_d = StIdle;
                done_d  = 1'b1;
              end else begin
                state_d = StStep;
              end
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      ca_cur_q   <= '0;
      byte_cnt_q <= '0;
      word_idx_q <= '0;
      out_gen_q  <= '0;
      gen_lat_q  <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      ca_cur_q   <= ca_cur_d;
      byte_cnt_q <= byte_cnt_d;
      word_idx_q <= word_idx_d;
      out_gen_q  <= out_gen_d;
      gen_lat_q  <= gen_lat_d;
      done_q     <= done_d;
    end
  end

  // Word 0 is the MSB slice; shift the selected word up to the top.
  assign word_sh = ca_cur_q << (OUT_W * word_idx_q);

  assign ca_cur     = ca_cur_q;
  assign out_gen    = out_gen_q;
  assign done       = done_q;
  assign busy       = (state_q != StIdle);
  assign seed_ready = (state_q == StLoad);
  assign out_valid  = (state_q == StDump);
  assign out_data   = word_sh[WIDTH-1 -: OUT_W];
  assign out_last   = (state_q == StDump) && (word_idx_q == LastWord);

endmodule

// File: tb/tb_rule110_gen_sequencer.sv
// Scoreboard bench for rule110_gen_sequencer with a behavioural Rule 110 step core and model.
module tb_rule110_gen_sequencer;

  localparam int unsigned WIDTH    = 256;
  localparam int unsigned OUT_W    = 16;
  localparam int unsigned GEN_W    = 8;
  localparam int unsigned NumWords = WIDTH / OUT_W;
  localparam int unsigned NumBytes = WIDTH / 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic             abort;
  logic [GEN_W-1:0] gen_count;
  logic             seed_valid;
  logic [7:0]       seed_data;
  logic             seed_ready;
  logic [WIDTH-1:0] ca_cur;
  logic [WIDTH-1:0] ca_next;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_data;
  logic             out_last;
  logic [GEN_W-1:0] out_gen;
  logic             busy;
  logic             done;

  rule110_gen_sequencer #(
    .WIDTH(WIDTH),
    .OUT_W(OUT_W),
    .GEN_W(GEN_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .abort     (abort),
    .gen_count (gen_count),
    .seed_valid(seed_valid),
    .seed_data (seed_data),
    .seed_ready(seed_ready),
    .ca_cur    (ca_cur),
    .ca_next   (ca_next),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_gen   (out_gen),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [OUT_W-1:0] data;
    logic             last;
    logic [GEN_W-1:0] gen;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_tests  = 0;
  int   n_fail   = 0;
  int   done_cnt = 0;

  // Rule 110 with zero cells beyond both ends; higher bit index is the left neighbour.
  function automatic logic [WIDTH-1:0] rule110(input logic [WIDTH-1:0] s);
    logic [7:0]       rule;
    logic [WIDTH+1:0] ext;
    logic [WIDTH-1:0] n;
    rule = 8'd110;
    ext  = {1'b0, s, 1'b0};
    for (int i = 0; i < WIDTH; i++) n[i] = rule[ext[i+2 -: 3]];
    return n;
  endfunction

  assign ca_next = rule110(ca_cur);

  task automatic chk(input string name, input logic [WIDTH-1:0] act,
                     input logic [WIDTH-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: compares every presented word against the scoreboard head.
  always @(negedge clk) begin
    if (rst_n) begin
      if (done) done_cnt++;
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          if (out_ready) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_word: got %0h gen %0d, expected no word", out_data, out_gen);
          end
        end else begin
          mon_e = exp_q[0];
          chk("word_data", out_data, mon_e.data);
          chk("word_last", out_last, mon_e.last);
          chk("word_gen", out_gen, mon_e.gen);
          if (out_ready) void'(exp_q.pop_front());
        end
      end
    end
  end

  task automatic chk_reset_outputs();
    chk("rst_busy", busy, 0);
    chk("rst_seed_ready", seed_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_done", done, 0);
    chk("rst_ca_cur", ca_cur, 0);
    chk("rst_out_gen", out_gen, 0);
  endtask

  // ready_mode: 0 always ready, 1 pattern 1,0,0,1, 2 random. abort_gen: abort while dumping it.
  task automatic run(input int gcnt, input int nframes, input int ready_mode,
                     input int abort_gen, input bit noise, input bit directed);
    logic [7:0]       seed_b [NumBytes];
    logic [WIDTH-1:0] s;
    logic [WIDTH-1:0] seed_s;
    logic [WIDTH-1:0] s_abort;
    exp_t             e;
    int               d0;
    int               stall;
    int               last_g;
    bit               aborted;
    for (int i = 0; i < NumBytes; i++) begin
      if (directed) seed_b[i] = (i == NumBytes - 1) ? 8'h01 : 8'h00;
      else          seed_b[i] = 8'($urandom);
    end
    s = '0;
    for (int i = 0; i < NumBytes; i++) s[WIDTH-1-8*i -: 8] = seed_b[i];
    seed_s  = s;
    s_abort = '0;
    last_g  = (abort_gen > nframes) ? abort_gen : nframes;
    for (int g = 1; g <= last_g; g++) begin
      s = rule110(s);
      if (g == abort_gen) s_abort = s;
      if (g <= nframes) begin
        for (int k = 0; k < NumWords; k++) begin
          e.data = s[WIDTH-1-k*OUT_W -: OUT_W];
          e.last = (k == NumWords - 1);
          e.gen  = GEN_W'(g);
          exp_q.push_back(e);
        end
      end
    end

    d0        = done_cnt;
    gen_count = GEN_W'(gcnt);
    start     = 1'b1;
    tick();
    start     = 1'b0;
    gen_count = GEN_W'($urandom);
    chk("start_seed_ready", seed_ready, 1);
    chk("start_ca_cleared", ca_cur, 0);
    chk("start_gen_cleared", out_gen, 0);

    for (int i = 0; i < NumBytes; i++) begin
      seed_valid = 1'b0;
      repeat ($urandom_range(0, 2)) tick();
      seed_valid = 1'b1;
      seed_data  = seed_b[i];
      tick();
    end
    seed_valid = 1'b0;
    chk("seed_loaded", ca_cur, seed_s);

    if (nframes == 0 && abort_gen == 0) begin
      chk("zero_gen_done", done, 1);
      chk("zero_gen_busy", busy, 0);
      chk("zero_gen_valid", out_valid, 0);
    end else begin
      chk("step_no_valid", out_valid, 0);
      tick();
      chk("first_valid", out_valid, 1);
      chk("first_gen", out_gen, 1);
    end

    aborted = 1'b0;
    stall   = 0;
    for (int cyc = 0; cyc < 5000 && busy; cyc++) begin
      case (ready_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      if (abort_gen != 0 && out_gen == GEN_W'(abort_gen)) begin
        out_ready = 1'b0;
        if (out_valid) stall++;
        if (stall == 3) abort = 1'b1;
      end
      if (noise) begin
        start      = out_valid & 1'($urandom_range(0, 1));
        seed_valid = !seed_ready & 1'($urandom_range(0, 1));
        seed_data  = 8'($urandom);
      end
      tick();
      start      = 1'b0;
      seed_valid = 1'b0;
      if (abort) begin
        abort   = 1'b0;
        aborted = 1'b1;
        chk("abort_valid", out_valid, 0);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_gen_kept", out_gen, GEN_W'(abort_gen));
        chk("abort_ca_kept", ca_cur, s_abort);
      end
    end
    chk("run_timeout", busy, 0);
    out_ready = 1'b0;
    tick();
    chk("done_pulses", done_cnt - d0, aborted ? 0 : 1);
    chk("done_one_cycle", done, 0);
    chk("queue_drained", exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    rst_n      = 1'b0;
    start      = 1'b0;
    abort      = 1'b0;
    gen_count  = '0;
    seed_valid = 1'b0;
    seed_data  = '0;
    out_ready  = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    chk_reset_outputs();

    run(3, 3, 0, 0, 1'b0, 1'b1);
    run(3, 3, 1, 0, 1'b0, 1'b1);
`ifdef RULE110_SEQ_FREERUN_EN
    run(0, 2, 0, 3, 1'b0, 1'b0);
`else
    run(0, 0, 0, 0, 1'b0, 1'b0);
`endif
    run(4, 1, 0, 2, 1'b0, 1'b0);
    run(1, 1, 0, 0, 1'b0, 1'b0);
    run(3, 3, 2, 0, 1'b1, 1'b0);

    // Reset in the middle of a seed load.
    gen_count = 8'd2;
    start     = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      seed_valid = 1'b1;
      seed_data  = 8'($urandom) | 8'h01;
      tick();
    end
    seed_valid = 1'b0;
    chk("pre_reset_busy", busy, 1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk_reset_outputs();
    tick();
    chk("post_reset_busy", busy, 0);

    for (int r = 0; r < 4; r++) begin
      int g;
      g = $urandom_range(1, 4);
      run(g, g, $urandom_range(0, 2), 0, 1'($urandom_range(0, 1)), 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
